// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: decoded operation encoding and memory-op classification.
package cpu_types_pkg;

   typedef enum logic [5:0] {
      CU_LUI   = 6'd0,
      CU_AUIPC = 6'd1,
      CU_JAL   = 6'd2,
      CU_JALR  = 6'd3,
      CU_BEQ   = 6'd4,
      CU_BNE   = 6'd5,
      CU_BLT   = 6'd6,
      CU_BGE   = 6'd7,
      CU_BLTU  = 6'd8,
      CU_BGEU  = 6'd9,
      CU_LB    = 6'd10,
      CU_LH    = 6'd11,
      CU_LW    = 6'd12,
      CU_LBU   = 6'd13,
      CU_LHU   = 6'd14,
      CU_SB    = 6'd15,
      CU_SH    = 6'd16,
      CU_SW    = 6'd17,
      CU_ADDI  = 6'd18,
      CU_SLTI  = 6'd19,
      CU_SLTIU = 6'd20,
      CU_XORI  = 6'd21,
      CU_ORI   = 6'd22,
      CU_ANDI  = 6'd23,
      CU_SLLI  = 6'd24,
      CU_SRLI  = 6'd25,
      CU_SRAI  = 6'd26,
      CU_ADD   = 6'd27,
      CU_SUB   = 6'd28,
      CU_SLL   = 6'd29,
      CU_SLT   = 6'd30,
      CU_SLTU  = 6'd31,
      CU_XOR   = 6'd32,
      CU_SRL   = 6'd33,
      CU_SRA   = 6'd34,
      CU_OR    = 6'd35,
      CU_AND   = 6'd36,
      CU_ERROR = 6'd63
   } cuOPType;

   function automatic logic is_load(input cuOPType op);
      return (op == CU_LB) || (op == CU_LH) || (op == CU_LW) ||
             (op == CU_LBU) || (op == CU_LHU);
   endfunction

   function automatic logic is_store(input cuOPType op);
      return (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
   endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Combinational store-lane replication and load-lane extraction with sign/zero extension.
module mem_lane_format
   import cpu_types_pkg::*;
(
   input  cuOPType     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_in,
   input  logic [31:0] load_in,
   output logic [31:0] store_out,
   output logic [31:0] load_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo)
         2'd0:    byte_sel = load_in[7:0];
         2'd1:    byte_sel = load_in[15:8];
         2'd2:    byte_sel = load_in[23:16];
         default: byte_sel = load_in[31:24];
      endcase
      // Half lane uses only addr bit 1; a misaligned bit 0 is ignored.
      half_sel = addr_lo[1] ? load_in[31:16] : load_in[15:0];
   end

   always_comb begin
      store_out = store_in;
      case (op)
         CU_SB:   store_out = {4{store_in[7:0]}};
         CU_SH:   store_out = {2{store_in[15:0]}};
         default: store_out = store_in;
      endcase
   end

   always_comb begin
      load_out = load_in;
      case (op)
         CU_LB:   load_out = {{24{byte_sel[7]}}, byte_sel};
         CU_LBU:  load_out = {24'h000000, byte_sel};
         CU_LH:   load_out = {{16{half_sel[15]}}, half_sel};
         CU_LHU:  load_out = {16'h0000, half_sel};
         default: load_out = load_in;
      endcase
   end

endmodule

// File: rtl/request_unit.sv
// Memory request arbiter: registers data read/write requests off the fetch/data handshakes
// and formats addresses and data lanes between the core and the memories.
module request_unit
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        i_ready,
   input  logic        d_ready,
   input  cuOPType     cuOP,
   input  logic [31:0] dmmstorei,
   input  logic [31:0] dmmaddri,
   input  logic [31:0] imemaddri,
   input  logic [31:0] imemloadi,
   input  logic [31:0] dmmloadi,
   output logic        imemRen,
   output logic        dmmRen,
   output logic        dmmWen,
   output logic [31:0] dmmstoreo,
   output logic [31:0] dmmaddro,
   output logic [31:0] imemaddro,
   output logic [31:0] imemloado,
   output logic [31:0] dmmloado
);

   // nRST is an active-high synchronous reset despite its name.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         dmmRen <= 1'b0;
         dmmWen <= 1'b0;
      end else if (i_ready) begin
         dmmRen <= is_load(cuOP);
         dmmWen <= is_store(cuOP);
      end else if (d_ready) begin
         dmmRen <= 1'b0;
         dmmWen <= 1'b0;
      end
   end

   assign imemRen   = ~nRST;
   assign imemaddro = imemaddri;
   assign imemloado = imemloadi;
   assign dmmaddro  = {dmmaddri[31:2], 2'b00};

   mem_lane_format u_lane (
      .op        (cuOP),
      .addr_lo   (dmmaddri[1:0]),
      .store_in  (dmmstorei),
      .load_in   (dmmloadi),
      .store_out (dmmstoreo),
      .load_out  (dmmloado)
   );

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios plus randomized traffic
// compared against a behavioural model every cycle.
module tb_request_unit;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;
   logic        i_ready = 1'b0, d_ready = 1'b0;
   cuOPType     cuOP = CU_ADD;
   logic [31:0] dmmstorei = '0, dmmaddri = '0, imemaddri = '0, imemloadi = '0, dmmloadi = '0;
   logic        imemRen, dmmRen, dmmWen;
   logic [31:0] dmmstoreo, dmmaddro, imemaddro, imemloado, dmmloado;

   int n_tests = 0;
   int n_fail  = 0;
   logic cmp_en = 1'b0;
   logic exp_ren = 1'b0, exp_wen = 1'b0;

   request_unit dut (
      .CLK(CLK), .nRST(nRST), .i_ready(i_ready), .d_ready(d_ready), .cuOP(cuOP),
      .dmmstorei(dmmstorei), .dmmaddri(dmmaddri), .imemaddri(imemaddri),
      .imemloadi(imemloadi), .dmmloadi(dmmloadi), .imemRen(imemRen),
      .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmstoreo(dmmstoreo), .dmmaddro(dmmaddro),
      .imemaddro(imemaddro), .imemloado(imemloado), .dmmloado(dmmloado)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: lanes computed arithmetically from the op class.
   function automatic bit m_load(input cuOPType op);
      return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
   endfunction

   function automatic bit m_store(input cuOPType op);
      return op inside {CU_SB, CU_SH, CU_SW};
   endfunction

   function automatic logic [31:0] m_storeo(input cuOPType op, input logic [31:0] s);
      if (op == CU_SB) return (s & 32'hFF) * 32'h01010101;
      if (op == CU_SH) return (s & 32'hFFFF) * 32'h00010001;
      return s;
   endfunction

   function automatic logic [31:0] m_loado(input cuOPType op, input logic [31:0] a,
                                           input logic [31:0] raw);
      logic [31:0] b, h;
      b = (raw >> (8 * a[1:0])) & 32'hFF;
      h = (raw >> (16 * a[1])) & 32'hFFFF;
      case (op)
         CU_LBU:  return b;
         CU_LHU:  return h;
         CU_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
         CU_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
         default: return raw;
      endcase
   endfunction

   always @(posedge CLK) begin
      if (nRST) begin
         exp_ren = 1'b0;
         exp_wen = 1'b0;
      end else if (i_ready) begin
         exp_ren = m_load(cuOP);
         exp_wen = m_store(cuOP);
      end else if (d_ready) begin
         exp_ren = 1'b0;
         exp_wen = 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("m_dmmRen", {31'd0, dmmRen}, {31'd0, exp_ren});
         chk("m_dmmWen", {31'd0, dmmWen}, {31'd0, exp_wen});
         chk("m_imemRen", {31'd0, imemRen}, {31'd0, ~nRST});
         chk("m_dmmaddro", dmmaddro, dmmaddri - (dmmaddri % 4));
         chk("m_imemaddro", imemaddro, imemaddri);
         chk("m_imemloado", imemloado, imemloadi);
         chk("m_dmmstoreo", dmmstoreo, m_storeo(cuOP, dmmstorei));
         chk("m_dmmloado", dmmloado, m_loado(cuOP, dmmaddri, dmmloadi));
      end
   end

   task automatic cyc();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      // Reset held for two cycles with a load decoded and fetch ready.
      #1;
      nRST = 1'b1; cuOP = CU_LH; i_ready = 1'b1;
      cyc();
      cmp_en = 1'b1;
      @(negedge CLK);
      chk("rst_ren", {31'd0, dmmRen}, 32'd0);
      chk("rst_wen", {31'd0, dmmWen}, 32'd0);
      chk("rst_imemRen", {31'd0, imemRen}, 32'd0);
      #1;

      nRST = 1'b0; i_ready = 1'b1; d_ready = 1'b0; cuOP = CU_LB;
      dmmaddri = 32'h00010001; imemaddri = 32'h12341234;
      @(negedge CLK);
      chk("ld_ren", {31'd0, dmmRen}, 32'd1);
      chk("ld_wen", {31'd0, dmmWen}, 32'd0);
      chk("ld_imemRen", {31'd0, imemRen}, 32'd1);
      chk("ld_addr", dmmaddro, 32'h00010000);
      chk("ld_iaddr", imemaddro, 32'h12341234);
      #1;

      i_ready = 1'b0; d_ready = 1'b1; cuOP = CU_LH;
      @(negedge CLK);
      chk("done_ren", {31'd0, dmmRen}, 32'd0);
      chk("done_wen", {31'd0, dmmWen}, 32'd0);
      #1;
      d_ready = 1'b0;
      @(negedge CLK);
      chk("hold_ren", {31'd0, dmmRen}, 32'd0);
      #1;

      i_ready = 1'b1; cuOP = CU_SW; dmmstorei = 32'hABCDABCD;
      @(negedge CLK);
      chk("st_wen", {31'd0, dmmWen}, 32'd1);
      chk("st_ren", {31'd0, dmmRen}, 32'd0);
      chk("st_sw", dmmstoreo, 32'hABCDABCD);
      #1;
      i_ready = 1'b0; cuOP = CU_SB; dmmstorei = 32'h000000CD;
      @(negedge CLK);
      chk("st_sb", dmmstoreo, 32'hCDCDCDCD);
      chk("st_hold_wen", {31'd0, dmmWen}, 32'd1);
      #1;

      dmmloadi = 32'h80FF7F01;
      cuOP = CU_LB;  dmmaddri = 32'h00000002; #1; chk("lb_2", dmmloado, 32'hFFFFFFFF);
      cuOP = CU_LBU; dmmaddri = 32'h00000003; #1; chk("lbu_3", dmmloado, 32'h00000080);
      cuOP = CU_LH;  dmmaddri = 32'h00000000; #1; chk("lh_0", dmmloado, 32'h00007F01);
      cuOP = CU_LHU; dmmaddri = 32'h00000002; #1; chk("lhu_2", dmmloado, 32'h000080FF);
      cuOP = CU_LH;  dmmaddri = 32'h00000003; #1; chk("lh_mis", dmmloado, 32'hFFFF80FF);
      cuOP = CU_LW;  dmmaddri = 32'h00000001; #1; chk("lw", dmmloado, 32'h80FF7F01);
      cyc();

      i_ready = 1'b1; d_ready = 1'b1; cuOP = CU_LW;
      @(negedge CLK);
      chk("prio_ren", {31'd0, dmmRen}, 32'd1);
      #1;
      nRST = 1'b1;
      @(negedge CLK);
      chk("midrst_ren", {31'd0, dmmRen}, 32'd0);
      chk("midrst_imemRen", {31'd0, imemRen}, 32'd0);
      #1;

      for (int i = 0; i < 3000; i++) begin
         nRST      = ($urandom_range(0, 39) == 0);
         i_ready   = ($urandom_range(0, 3) == 0);
         d_ready   = ($urandom_range(0, 2) == 0);
         cuOP      = ($urandom_range(0, 1) == 0) ? cuOPType'(6'($urandom_range(10, 17)))
                                                 : cuOPType'(6'($urandom_range(0, 63)));
         dmmstorei = $urandom;
         dmmaddri  = $urandom;
         imemaddri = $urandom;
         imemloadi = $urandom;
         dmmloadi  = $urandom;
         cyc();
      end

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
